// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Shares one synchronous sprite/background ROM port among NUM_REQ
//            pixel-fetch requesters; returns each ROM word to its issuer.
//            Macro SPRITE_ARB_PRIO0_EN gives requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int               PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   C_NUM = (PTR_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]    rom_address_q, rom_address_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [ROM_LAT:0]     pipe_vld_q, pipe_vld_d;
    logic [PTR_W-1:0]     pipe_id_q [ROM_LAT+1];
    logic [PTR_W-1:0]     pipe_id_d [ROM_LAT+1];

    logic [NUM_REQ-1:0]   w_elig, w_elig_rr;
    logic [2*NUM_REQ-1:0] w_elig_rot;
    logic                 w_rr_found;
    logic [PTR_W:0]       w_rr_off, w_rr_sum, w_ptr_nxt;
    logic [PTR_W-1:0]     w_rr_idx, w_win;
    logic                 w_grant;

    // Round-robin search: rotate so ptr lands at bit 0, take the lowest hit.
    always_comb begin
        w_elig    = req & ~gnt_q & {NUM_REQ{enable}};
        w_elig_rr = w_elig;
`ifdef SPRITE_ARB_PRIO0_EN
        w_elig_rr[0] = 1'b0;
`endif
        w_elig_rot = {w_elig_rr, w_elig_rr} >> ptr_q;
        w_rr_found = 1'b0;
        w_rr_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_elig_rot[k]) begin
                w_rr_found = 1'b1;
                w_rr_off   = (PTR_W+1)'(k);
            end
        end
        w_rr_sum = {1'b0, ptr_q} + w_rr_off;
        if (w_rr_sum >= C_NUM) begin
            w_rr_sum = w_rr_sum - C_NUM;
        end
        w_rr_idx  = w_rr_sum[PTR_W-1:0];
        w_ptr_nxt = {1'b0, w_rr_idx} + (PTR_W+1)'(1);
        if (w_ptr_nxt >= C_NUM) begin
            w_ptr_nxt = '0;
        end
    end

    always_comb begin
        w_grant = 1'b0;
        w_win   = '0;
        ptr_d   = ptr_q;
`ifdef SPRITE_ARB_PRIO0_EN
        // Requester 0 bypasses the pointer entirely.
        if (w_elig[0]) begin
            w_grant = 1'b1;
            w_win   = '0;
        end else if (w_rr_found) begin
            w_grant = 1'b1;
            w_win   = w_rr_idx;
            ptr_d   = w_ptr_nxt[PTR_W-1:0];
        end
`else
        if (w_rr_found) begin
            w_grant = 1'b1;
            w_win   = w_rr_idx;
            ptr_d   = w_ptr_nxt[PTR_W-1:0];
        end
`endif
        gnt_d         = '0;
        rom_address_d = rom_address_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_win == PTR_W'(i))) begin
                gnt_d[i]      = 1'b1;
                rom_address_d = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Stage ROM_LAT lines up with rom_q for the read issued ROM_LAT+1 edges ago.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = w_grant;
        pipe_id_d[0]  = w_win;
        for (int s = 1; s <= ROM_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
        end
        busy_d = |pipe_vld_d;

        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = pipe_vld_q[ROM_LAT] && (pipe_id_q[ROM_LAT] == PTR_W'(i));
        end
        rsp_data_d = pipe_vld_q[ROM_LAT] ? rom_q : rsp_data_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q         <= '0;
            rom_address_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            ptr_q         <= '0;
            pipe_vld_q    <= '0;
            for (int s = 0; s <= ROM_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            gnt_q         <= gnt_d;
            rom_address_q <= rom_address_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            pipe_vld_q    <= pipe_vld_d;
            for (int s = 0; s <= ROM_LAT; s++) begin
                pipe_id_q[s] <= pipe_id_d[s];
            end
        end
    end

    assign gnt         = gnt_q;
    assign rom_address = rom_address_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Brief    : Directed self-checking bench for sprite_rom_arbiter (4 requesters,
//            ROM_LAT=1); ROM model returns address[3:0] ^ 4'h5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 4;
    localparam int ROM_LAT = 1;

    logic                      vga_clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      enable  = 1'b1;
    logic [NUM_REQ-1:0]        req     = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    int n_vec  = 0;
    int n_miss = 0;

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) u_dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_address[3:0] ^ 4'h5;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk_cyc(input string tag, input logic [3:0] g, input logic [17:0] a,
                           input logic [3:0] rv, input logic [3:0] rd, input logic b);
        chk_eq({tag, " gnt"},       32'(gnt), 32'(g));
        chk_eq({tag, " rom_addr"},  32'(rom_address), 32'(a));
        chk_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'(rv));
        chk_eq({tag, " rsp_data"},  32'(rsp_data), 32'(rd));
        chk_eq({tag, " busy"},      32'(busy), 32'(b));
    endtask

    task automatic do_reset(input logic [3:0] r);
        reset_n = 1'b0;
        enable  = 1'b1;
        req     = r;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  g;
        logic [17:0] a;
        logic [3:0]  rv;
        logic [3:0]  rd;
        logic        b;
    } row_t;

    row_t rr_tab [8];

    initial begin
`ifdef SPRITE_ARB_PRIO0_EN
        rr_tab[0] = '{4'b0001, 18'h100, 4'b0000, 4'h0, 1'b1};
        rr_tab[1] = '{4'b0010, 18'h101, 4'b0000, 4'h0, 1'b1};
        rr_tab[2] = '{4'b0001, 18'h100, 4'b0001, 4'h5, 1'b1};
        rr_tab[3] = '{4'b0100, 18'h102, 4'b0010, 4'h4, 1'b1};
        rr_tab[4] = '{4'b0001, 18'h100, 4'b0001, 4'h5, 1'b1};
        rr_tab[5] = '{4'b0000, 18'h100, 4'b0100, 4'h7, 1'b1};
        rr_tab[6] = '{4'b0000, 18'h100, 4'b0001, 4'h5, 1'b0};
        rr_tab[7] = '{4'b0000, 18'h100, 4'b0000, 4'h5, 1'b0};
`else
        rr_tab[0] = '{4'b0001, 18'h100, 4'b0000, 4'h0, 1'b1};
        rr_tab[1] = '{4'b0010, 18'h101, 4'b0000, 4'h0, 1'b1};
        rr_tab[2] = '{4'b0100, 18'h102, 4'b0001, 4'h5, 1'b1};
        rr_tab[3] = '{4'b1000, 18'h103, 4'b0010, 4'h4, 1'b1};
        rr_tab[4] = '{4'b0001, 18'h100, 4'b0100, 4'h7, 1'b1};
        rr_tab[5] = '{4'b0000, 18'h100, 4'b1000, 4'h6, 1'b1};
        rr_tab[6] = '{4'b0000, 18'h100, 4'b0001, 4'h5, 1'b0};
        rr_tab[7] = '{4'b0000, 18'h100, 4'b0000, 4'h5, 1'b0};
`endif

        // Reset holds everything low even with all requests pending.
        req_addr = {18'h103, 18'h102, 18'h101, 18'h100};
        do_reset(4'b1111);
        chk_cyc("reset", 4'b0000, 18'h0, 4'b0000, 4'h0, 1'b0);

        // All four requesting; drop requests after the fifth cycle.
        for (int c = 0; c < 8; c++) begin
            tick();
            chk_cyc($sformatf("rr c%0d", c + 1), rr_tab[c].g, rr_tab[c].a,
                    rr_tab[c].rv, rr_tab[c].rd, rr_tab[c].b);
            if (c == 4) req = 4'b0000;
        end

        // Lone requester 2: grant every other cycle only.
        req_addr = {18'h0, 18'h0A7, 18'h0, 18'h0};
        do_reset(4'b0000);
        req = 4'b0100;
        tick(); chk_cyc("single c1", 4'b0100, 18'h0A7, 4'b0000, 4'h0, 1'b1);
        tick(); chk_cyc("single c2", 4'b0000, 18'h0A7, 4'b0000, 4'h0, 1'b1);
        tick(); chk_cyc("single c3", 4'b0100, 18'h0A7, 4'b0100, 4'h2, 1'b1);
        tick(); chk_cyc("single c4", 4'b0000, 18'h0A7, 4'b0000, 4'h2, 1'b1);
        tick(); chk_cyc("single c5", 4'b0100, 18'h0A7, 4'b0100, 4'h2, 1'b1);
        req = 4'b0000;

        // Enable low after grant to 1: response still returns, ptr held.
        req_addr = {18'h0, 18'h0C4, 18'h0B3, 18'h0};
        do_reset(4'b0000);
        req = 4'b0110;
        tick(); chk_cyc("en c1", 4'b0010, 18'h0B3, 4'b0000, 4'h0, 1'b1);
        enable = 1'b0;
        tick(); chk_cyc("en c2", 4'b0000, 18'h0B3, 4'b0000, 4'h0, 1'b1);
        tick(); chk_cyc("en c3", 4'b0000, 18'h0B3, 4'b0010, 4'h6, 1'b0);
        tick(); chk_cyc("en c4", 4'b0000, 18'h0B3, 4'b0000, 4'h6, 1'b0);
        enable = 1'b1;
        tick(); chk_cyc("en c5", 4'b0100, 18'h0C4, 4'b0000, 4'h6, 1'b1);
        req = 4'b0000;

        // Async reset one cycle after a grant discards the read.
        req_addr = {18'h0, 18'h0, 18'h0, 18'h0D1};
        do_reset(4'b0000);
        req = 4'b0001;
        tick(); chk_cyc("arst c1", 4'b0001, 18'h0D1, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        tick(); chk_cyc("arst c2", 4'b0000, 18'h0D1, 4'b0000, 4'h0, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_cyc("arst now", 4'b0000, 18'h0, 4'b0000, 4'h0, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_cyc($sformatf("arst post c%0d", c + 1), 4'b0000, 18'h0, 4'b0000, 4'h0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
